// File: rtl/dither_dpwm_param.sv
// dither_dpwm_param: splits a DW_IN-bit duty command into a DW_OUT-bit integer
// part plus a K-bit fraction, and dithers the integer part by one LSB across a
// 2^K-step frame so a DW_OUT-bit DPWM achieves DW_IN-bit average resolution.
// MODE 0 uses a bit-reversed counter pattern with the command latched at frame
// start; MODE 1 uses a first-order error accumulator fed every step.
module dither_dpwm_param #(
   parameter int DW_IN  = 9,
   parameter int DW_OUT = 6,
   parameter int MODE   = 0
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              en,
   input  logic              tick,
   input  logic              sync_clr,
   input  logic [DW_IN-1:0]  d_in,
   output logic [DW_OUT-1:0] duty_out,
   output logic              frame_start,
   output logic              sat
);

   localparam int K = DW_IN - DW_OUT;

   logic [K-1:0]      cnt_q, cnt_d;
   logic [K-1:0]      acc_q, acc_d;
   logic [DW_IN-1:0]  d_lat_q, d_lat_d;
   logic [DW_OUT-1:0] duty_q, duty_d;
   logic              fs_q, fs_d;
   logic              sat_q, sat_d;

   // Step datapath signals
   logic [DW_IN-1:0]  d_eff;
   logic [DW_OUT-1:0] int_part;
   logic [K-1:0]      frac;
   logic [K:0]        acc_sum;
   logic              dith_b;
   logic [DW_OUT:0]   sum;

   // Bit reversal spreads the frac ones evenly across the frame
   function automatic logic [K-1:0] bitrev(input logic [K-1:0] v);
      logic [K-1:0] r;
      for (int i = 0; i < K; i++) r[i] = v[K-1-i];
      return r;
   endfunction

   // Dither datapath: effective command, dither bit, saturating sum
   always_comb begin
      // Pattern mode holds the command for the whole frame so the per-frame
      // average is exact; sigma-delta tracks the input every step.
      d_eff    = (MODE == 1 || cnt_q == '0) ? d_in : d_lat_q;
      int_part = d_eff[DW_IN-1:K];
      frac     = d_eff[K-1:0];
      acc_sum  = {1'b0, acc_q} + {1'b0, frac};
      dith_b   = (MODE == 1) ? acc_sum[K] : (bitrev(cnt_q) < frac);
      sum      = {1'b0, int_part} + {{DW_OUT{1'b0}}, dith_b};
   end

   // Next-state: sync_clr beats tick; en low freezes everything
   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      d_lat_d = d_lat_q;
      duty_d  = duty_q;
      fs_d    = fs_q;
      sat_d   = sat_q;
      if (en) begin
         if (sync_clr) begin
            cnt_d = '0;
            acc_d = '0;
            fs_d  = 1'b0;
         end else if (tick) begin
            if (MODE == 0 && cnt_q == '0) d_lat_d = d_in;
            if (MODE == 1) acc_d = acc_sum[K-1:0];
            if (sum[DW_OUT]) begin
               duty_d = '1;
               sat_d  = 1'b1;
            end else begin
               duty_d = sum[DW_OUT-1:0];
               sat_d  = 1'b0;
            end
            fs_d  = (cnt_q == '0);
            cnt_d = cnt_q + K'(1);
         end else begin
            fs_d = 1'b0;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         d_lat_q <= '0;
         duty_q  <= '0;
         fs_q    <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         d_lat_q <= d_lat_d;
         duty_q  <= duty_d;
         fs_q    <= fs_d;
         sat_q   <= sat_d;
      end
   end

   assign duty_out    = duty_q;
   assign frame_start = fs_q;
   assign sat         = sat_q;

endmodule

// File: tb/tb_dither_dpwm_param.sv
// Bench for dither_dpwm_param: a MODE 0 and a MODE 1 instance share stimulus.
// Each issued step pushes its hand-computed result; a monitor pops and
// compares one cycle later, and checks that outputs hold between steps.
module tb_dither_dpwm_param;

   logic       clk_in = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       tick = 1'b0;
   logic       sync_clr = 1'b0;
   logic [8:0] d_in = '0;
   logic [5:0] duty0, duty1;
   logic       fs0, fs1, sat0, sat1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         sel;
      logic [5:0] duty;
      logic       sat;
      logic       fs;
   } exp_t;
   exp_t exp_q[$];

   dither_dpwm_param #(.DW_IN(9), .DW_OUT(6), .MODE(0)) dut0 (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .tick(tick), .sync_clr(sync_clr),
      .d_in(d_in), .duty_out(duty0), .frame_start(fs0), .sat(sat0));

   dither_dpwm_param #(.DW_IN(9), .DW_OUT(6), .MODE(1)) dut1 (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .tick(tick), .sync_clr(sync_clr),
      .d_in(d_in), .duty_out(duty1), .frame_start(fs1), .sat(sat1));

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // One step on the next edge, with its expected response queued
   task automatic step_tick(input logic [8:0] d, input int sel,
                            input logic [5:0] ed, input logic es, input logic ef);
      exp_t e;
      e.sel = sel; e.duty = ed; e.sat = es; e.fs = ef;
      exp_q.push_back(e);
      d_in = d; en = 1'b1; tick = 1'b1; sync_clr = 1'b0;
      @(posedge clk_in); #1;
      tick = 1'b0;
   endtask

   task automatic idle(input int n);
      tick = 1'b0;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic clr_cycle(input logic with_tick);
      en = 1'b1; tick = with_tick; sync_clr = 1'b1;
      @(posedge clk_in); #1;
      sync_clr = 1'b0; tick = 1'b0;
   endtask

   // Monitor: compare popped expectations on step cycles, hold checks otherwise
   initial begin
      logic       stepped, en_s, prev_ok, prev_fs, prev_sat;
      logic [5:0] prev_duty;
      exp_t       e;
      prev_ok = 1'b0; prev_fs = 1'b0; prev_sat = 1'b0; prev_duty = '0;
      forever begin
         @(posedge clk_in);
         stepped = rst_n && en && tick && !sync_clr;
         en_s    = en;
         @(negedge clk_in);
         if (stepped) begin
            if (exp_q.size() == 0) begin
               chk("queue_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               if (e.sel == 0) begin
                  chk("m0_duty", duty0, e.duty);
                  chk("m0_sat", sat0, e.sat);
                  chk("m0_fs", fs0, e.fs);
               end else begin
                  chk("m1_duty", duty1, e.duty);
                  chk("m1_sat", sat1, e.sat);
                  chk("m1_fs", fs1, e.fs);
               end
            end
         end else if (prev_ok && rst_n) begin
            chk("hold_duty", duty0, prev_duty);
            chk("hold_sat", sat0, prev_sat);
            chk("hold_fs", fs0, en_s ? 0 : prev_fs);
         end
         prev_duty = duty0; prev_sat = sat0; prev_fs = fs0;
         prev_ok   = rst_n;
      end
   end

   initial begin
      logic [5:0] pat[8];
      logic [5:0] sd[8];
      pat = '{6'd2, 6'd2, 6'd2, 6'd1, 6'd2, 6'd1, 6'd2, 6'd1};
      sd  = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 6'd1, 6'd0, 6'd1};

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_duty0", duty0, 0); chk("rst_sat0", sat0, 0); chk("rst_fs0", fs0, 0);
      chk("rst_duty1", duty1, 0); chk("rst_sat1", sat1, 0); chk("rst_fs1", fs1, 0);
      rst_n = 1'b1;
      en = 1'b1;
      idle(2);

      // Pattern dither, back-to-back ticks, two frames
      for (int i = 0; i < 16; i++) step_tick(9'd13, 0, pat[i%8], 1'b0, (i % 8) == 0);
      idle(2);

      // Saturation: clamp on every step except the one with b=0
      for (int i = 0; i < 8; i++) step_tick(9'h1FF, 0, 6'd63, i < 7, i == 0);
      idle(2);

      // Frame alignment: mid-frame command change waits for next frame
      for (int i = 0; i < 3; i++) step_tick(9'd8, 0, 6'd1, 1'b0, i == 0);
      for (int i = 3; i < 8; i++) step_tick(9'd16, 0, 6'd1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step_tick(9'd16, 0, 6'd2, 1'b0, i == 0);
      idle(2);

      // Sigma-delta from a cleared accumulator, two frames
      clr_cycle(1'b0);
      for (int i = 0; i < 16; i++) step_tick(9'd3, 1, sd[i%8], 1'b0, (i % 8) == 0);
      idle(2);

      // Sparse ticks with en dropped mid-frame (a stray tick while disabled)
      for (int i = 0; i < 8; i++) begin
         step_tick(9'd13, 0, pat[i], 1'b0, i == 0);
         if (i == 0) begin
            // freeze right after the frame-start step: frame_start must hold
            en = 1'b0;
            idle(3);
            tick = 1'b1;
            @(posedge clk_in); #1;
            tick = 1'b0;
            idle(6);
            en = 1'b1;
         end
         if (i == 3) begin
            en = 1'b0;
            idle(10);
            en = 1'b1;
         end
         idle(4);
      end

      // sync_clr together with tick at cnt=4: no step, fresh frame follows
      for (int i = 0; i < 4; i++) step_tick(9'd13, 0, pat[i], 1'b0, i == 0);
      clr_cycle(1'b1);
      for (int i = 0; i < 3; i++) step_tick(9'd13, 0, pat[i], 1'b0, i == 0);
      idle(2);

      // Reset mid-frame at cnt=5, then frame restart latches d_in
      clr_cycle(1'b0);
      for (int i = 0; i < 5; i++) step_tick(9'd13, 0, pat[i], 1'b0, i == 0);
      @(negedge clk_in); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_duty0", duty0, 0); chk("mid_rst_sat0", sat0, 0); chk("mid_rst_fs0", fs0, 0);
      chk("mid_rst_duty1", duty1, 0); chk("mid_rst_sat1", sat1, 0); chk("mid_rst_fs1", fs1, 0);
      repeat (2) @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      idle(1);
      step_tick(9'd8, 0, 6'd1, 1'b0, 1'b1);
      // cnt=1 must use the latched 8, not the new 16
      step_tick(9'd16, 0, 6'd1, 1'b0, 1'b0);
      idle(3);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dither_dpwm_param.md
# dither_dpwm_param

Parametrised digital dither stage for the DPWM path. It splits a DW_IN-bit duty command into a DW_OUT-bit integer part and a K-bit fractional part, and dithers the integer part by one LSB over a 2^K-period frame. The result is average resolution DW_IN on a DW_OUT-bit counter-comparator. It sits between the compensator output and the DPWM core. Compared with the previous generation, it adds:
- pattern or first-order sigma-delta mode,
- advance on a PWM-period strobe,
- frame-aligned input latching,
- saturation and a registered output.

## Interface
- DW_IN, default 9: input duty width.
- DW_OUT, default 6: output duty width. K = DW_IN-DW_OUT, legal range 1..8; DW_OUT ≥ 2.
- MODE, default 0: 0 = bit-reversed pattern dither; 1 = first-order sigma-delta (error accumulator).

Ports:
- clk_in  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  enable; low freezes all state.
- tick  in  1  one-cycle strobe, one per PWM period; dither advances only on en&&tick.
- sync_clr  in  1  synchronous frame restart.
- d_in  in  DW_IN  duty command, unsigned.
- duty_out  out  DW_OUT  dithered duty to DPWM, registered.
- frame_start  out  1  registered pulse marking the first period of a frame.
- sat  out  1  registered; high while the dithered value was clamped.

## Operation
- Internal state:
  - frame counter cnt, K bits.
  - latched command d_lat, DW_IN bits.
  - accumulator acc, K bits (MODE 1 only).
- Step, on a rising edge with en=1, tick=1, sync_clr=0:
  - Select the effective command: d_eff = d_in if cnt==0, else d_lat. When cnt==0, also d_lat ← d_in. In MODE 1, d_eff = d_in every step; d_lat is unused.
  - Split the command: int = d_eff[DW_IN-1:K], frac = d_eff[K-1:0].
  - Dither bit b in MODE 0: b = (bitrev_K(cnt) < frac). This gives exactly frac ones per 2^K steps, evenly spread.
  - Dither bit b in MODE 1: {b, acc_next} = acc + frac, computed K+1 bits wide; acc ← acc_next.
  - Output sum: computed DW_OUT+1 bits wide as int + b. If the sum exceeds 2^DW_OUT−1, duty_out ← all ones and sat ← 1. Otherwise duty_out ← sum and sat ← 0.
  - Counter: cnt ← cnt+1, wrapping from 2^K−1 to 0. frame_start ← (cnt==0).
- Rising edge with en=1, tick=0, sync_clr=0: frame_start ← 0. Everything else holds.
- en=0: everything holds, including frame_start. The frame resumes at the held cnt when en returns.
- sync_clr=1 with en=1 has priority over tick. It sets cnt ← 0, acc ← 0 and frame_start ← 0; duty_out, sat and d_lat hold. The next step starts a new frame and latches d_in.
- Reset (rst_n=0, asynchronous): cnt, acc, d_lat, duty_out, frame_start and sat all go to 0. Release is synchronous to clk_in; the first step after release is a frame start.
- Command changes mid-frame (MODE 0) take effect at the next cnt==0 step only. The average is exact per frame.

## Timing
- Latency: duty_out, sat and frame_start update on the same edge that samples en&&tick. They are valid one clock after tick, before the DPWM loads at its next period.
- Back-to-back ticks on every cycle are legal and must be supported; there is no minimum spacing.
- No combinational path from inputs to outputs.
- Frame length is exactly 2^K steps; frame_start is high once per frame, for one cycle.
- Simultaneous tick and sync_clr: sync_clr wins and no step occurs.
- Reset asserted mid-frame aborts the frame with no partial output.

## Test plan
- Pattern dither (MODE 0, defaults):
  - Stimulus: d_in=9'd13 held (int 1, frac 5), tick every cycle.
  - Required response: duty_out over cnt 0..7 = 2,2,2,1,2,1,2,1, repeating; frame_start every 8th cycle.
- Saturation:
  - Stimulus: d_in=9'h1FF (int 63, frac 7).
  - Required response: duty_out=63 on every step. sat=1 on cnt 0..6; sat=0 on cnt 7.
- Frame alignment:
  - Stimulus: d_in=9'd8 for the first three ticks, then 9'd16 at cnt=3.
  - Required response: duty_out stays 1 until the next frame start, then 2 for all 8 steps.
- Sigma-delta (MODE 1):
  - Stimulus: d_in=9'd3 (int 0, frac 3).
  - Required response: b sequence 0,0,1,0,0,1,0,1; duty_out = 0,0,1,0,0,1,0,1; acc back to 0 after 8 steps.
- Control:
  - Stimulus: sparse tick (every 5 cycles) with en dropped for 10 cycles mid-frame.
  - Required response: outputs change only on the tick cycles, and the pattern continues unbroken.
  - Stimulus: sync_clr together with tick at cnt=4.
  - Required response: no step; the next tick gives frame_start=1.
- Reset:
  - Stimulus: rst_n asserted mid-frame at cnt=5.
  - Required response: all outputs go to 0 immediately; the first tick after release latches d_in and pulses frame_start.
